// File: rtl/multicycle_controller_if.sv
// ----------------------------------------------------------------------------
// multicycle_controller_if
//   Signal bundle between the multicycle controller and the shared MIPS-subset
//   datapath (IR, ALU/multiplier, data memory, register file).
//
//   Datapath -> controller:
//     Instruction[31:0]  current IR contents
//     BranchTaken        ALU branch-condition result
//     MemReady           data memory access completes this cycle
//   Controller -> datapath:
//     IRWrite, PCWrite, PCSrc[1:0], RegWrite, RegDst, ALUSrc, MemToReg,
//     MemRead[1:0], MemWrite[1:0], Jal, ShiftControl, ALUControl[4:0],
//     InstrDone, Trap, State[2:0]
//
//   master: the controller side.  slave: the datapath side.
// ----------------------------------------------------------------------------
interface multicycle_controller_if;
    logic [31:0] Instruction;
    logic        BranchTaken;
    logic        MemReady;

    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  PCSrc;
    logic        RegWrite;
    logic        RegDst;
    logic        ALUSrc;
    logic        MemToReg;
    logic [1:0]  MemRead;
    logic [1:0]  MemWrite;
    logic        Jal;
    logic        ShiftControl;
    logic [4:0]  ALUControl;
    logic        InstrDone;
    logic        Trap;
    logic [2:0]  State;

    modport master (
        input  Instruction, BranchTaken, MemReady,
        output IRWrite, PCWrite, PCSrc, RegWrite, RegDst, ALUSrc, MemToReg,
               MemRead, MemWrite, Jal, ShiftControl, ALUControl, InstrDone,
               Trap, State
    );

    modport slave (
        output Instruction, BranchTaken, MemReady,
        input  IRWrite, PCWrite, PCSrc, RegWrite, RegDst, ALUSrc, MemToReg,
               MemRead, MemWrite, Jal, ShiftControl, ALUControl, InstrDone,
               Trap, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//   Sequencer for the multicycle MIPS-subset datapath. Each instruction walks
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB]; every control strobe is raised
//   only in the cycle the shared datapath consumes it. EXEC is stretched to
//   MUL_CYCLES cycles for mul, MEM is stretched until MemReady. Undecodable
//   instructions park the controller in TRAP until reset.
//
//   Ports:
//     Clk    rising-edge clock
//     Rst_n  asynchronous active-low reset; all outputs read 0 while low
//     bus    multicycle_controller_if.master (IR, handshakes, strobes, debug)
//
//   Parameter:
//     MUL_CYCLES  EXEC residency for mul, 1..15
// ----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    multicycle_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_MUL  = 5'b00011;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_AND  = 5'b00110;
    localparam logic [4:0] ALU_OR   = 5'b00111;
    localparam logic [4:0] ALU_XOR  = 5'b01000;
    localparam logic [4:0] ALU_BEQ  = 5'b01100;
    localparam logic [4:0] ALU_NOR  = 5'b01101;
    localparam logic [4:0] ALU_SLT  = 5'b01110;
    localparam logic [4:0] ALU_BNE  = 5'b01111;  // also bgez
    localparam logic [4:0] ALU_BGTZ = 5'b10000;
    localparam logic [4:0] ALU_BLEZ = 5'b10001;
    localparam logic [4:0] ALU_BLTZ = 5'b10010;

    // Last mul_cnt value spent in EXEC; reaching it means MUL_CYCLES cycles.
    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

    // Instruction classification, recomputed every cycle from the IR.
    typedef struct packed {
        logic       legal;
        logic       is_j;
        logic       is_jal;
        logic       is_jr;
        logic       is_branch;
        logic       is_mul;
        logic       is_rtype;   // writes rd
        logic       is_imm;     // I-type ALU op, immediate operand
        logic       is_shift;   // shamt feeds ALU operand A
        logic       is_load;
        logic       is_store;
        logic [1:0] width;      // 01 word, 10 half, 11 byte
        logic [4:0] alu;
    } dec_t;

    state_t     state;
    logic [3:0] mul_cnt;
    dec_t       dec;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;

    assign op    = bus.Instruction[31:26];
    assign funct = bus.Instruction[5:0];
    assign rt    = bus.Instruction[20:16];

    // rs, rd, shamt and the immediate belong to the datapath, not to decode.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.Instruction[25:21], bus.Instruction[15:6]};

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a combinational variable unassigned (which would infer a latch).
        dec = '0;
        case (op)
            6'h00: begin
                dec.legal    = 1'b1;
                dec.is_rtype = 1'b1;
                case (funct)
                    6'h20: dec.alu = ALU_ADD;
                    6'h22: dec.alu = ALU_SUB;
                    6'h24: dec.alu = ALU_AND;
                    6'h25: dec.alu = ALU_OR;
                    6'h26: dec.alu = ALU_XOR;
                    6'h27: dec.alu = ALU_NOR;
                    6'h2A: dec.alu = ALU_SLT;
                    6'h00: begin dec.alu = ALU_SLL; dec.is_shift = 1'b1; end
                    6'h02: begin dec.alu = ALU_SRL; dec.is_shift = 1'b1; end
                    6'h08: begin dec.is_jr = 1'b1; dec.is_rtype = 1'b0; end
                    default: dec.legal = 1'b0;
                endcase
            end
            6'h1C: begin
                // SPECIAL2: only mul is implemented.
                if (funct == 6'h02) begin
                    dec.legal  = 1'b1;
                    dec.is_mul = 1'b1;
                    dec.alu    = ALU_MUL;
                end
            end
            6'h01: begin
                // REGIMM: rt selects bltz (0) or bgez (1).
                dec.is_branch = 1'b1;
                if (rt == 5'b00000) begin
                    dec.legal = 1'b1;
                    dec.alu   = ALU_BLTZ;
                end else if (rt == 5'b00001) begin
                    dec.legal = 1'b1;
                    dec.alu   = ALU_BNE;
                end
            end
            6'h02: begin dec.legal = 1'b1; dec.is_j   = 1'b1; end
            6'h03: begin dec.legal = 1'b1; dec.is_jal = 1'b1; end
            6'h04: begin dec.legal = 1'b1; dec.is_branch = 1'b1; dec.alu = ALU_BEQ;  end
            6'h05: begin dec.legal = 1'b1; dec.is_branch = 1'b1; dec.alu = ALU_BNE;  end
            6'h06: begin dec.legal = 1'b1; dec.is_branch = 1'b1; dec.alu = ALU_BLEZ; end
            6'h07: begin dec.legal = 1'b1; dec.is_branch = 1'b1; dec.alu = ALU_BGTZ; end
            6'h08: begin dec.legal = 1'b1; dec.is_imm = 1'b1; dec.alu = ALU_ADD; end
            6'h0A: begin dec.legal = 1'b1; dec.is_imm = 1'b1; dec.alu = ALU_SLT; end
            6'h0C: begin dec.legal = 1'b1; dec.is_imm = 1'b1; dec.alu = ALU_AND; end
            6'h0D: begin dec.legal = 1'b1; dec.is_imm = 1'b1; dec.alu = ALU_OR;  end
            6'h0E: begin dec.legal = 1'b1; dec.is_imm = 1'b1; dec.alu = ALU_XOR; end
            6'h20: begin dec.legal = 1'b1; dec.is_load  = 1'b1; dec.width = 2'b11; dec.alu = ALU_ADD; end
            6'h21: begin dec.legal = 1'b1; dec.is_load  = 1'b1; dec.width = 2'b10; dec.alu = ALU_ADD; end
            6'h23: begin dec.legal = 1'b1; dec.is_load  = 1'b1; dec.width = 2'b01; dec.alu = ALU_ADD; end
            6'h28: begin dec.legal = 1'b1; dec.is_store = 1'b1; dec.width = 2'b11; dec.alu = ALU_ADD; end
            6'h29: begin dec.legal = 1'b1; dec.is_store = 1'b1; dec.width = 2'b10; dec.alu = ALU_ADD; end
            6'h2B: begin dec.legal = 1'b1; dec.is_store = 1'b1; dec.width = 2'b01; dec.alu = ALU_ADD; end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // State sequencing
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!Rst_n) begin
            state   <= S_FETCH;
            mul_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (!dec.legal)
                        state <= S_TRAP;
                    else if (dec.is_j || dec.is_jal || dec.is_jr)
                        state <= S_FETCH;
                    else
                        state <= S_EXEC;
                end
                S_EXEC: begin
                    if (dec.is_branch) begin
                        state <= S_FETCH;
                    end else if (dec.is_mul) begin
                        if (mul_cnt < MUL_LAST) begin
                            mul_cnt <= mul_cnt + 4'd1;
                        end else begin
                            mul_cnt <= '0;
                            state   <= S_WB;
                        end
                    end else if (dec.is_load || dec.is_store) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.MemReady)
                        state <= dec.is_store ? S_FETCH : S_WB;
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control strobes: decoded from registered state plus the IR
    // ------------------------------------------------------------------------
    always_comb begin
        bus.IRWrite      = 1'b0;
        bus.PCWrite      = 1'b0;
        bus.PCSrc        = 2'b00;
        bus.RegWrite     = 1'b0;
        bus.RegDst       = 1'b0;
        bus.ALUSrc       = 1'b0;
        bus.MemToReg     = 1'b0;
        bus.MemRead      = 2'b00;
        bus.MemWrite     = 2'b00;
        bus.Jal          = 1'b0;
        bus.ShiftControl = 1'b0;
        bus.ALUControl   = 5'b00000;
        bus.InstrDone    = 1'b0;
        bus.Trap         = 1'b0;
        bus.State        = 3'd0;

        // Rst_n gates the whole decode: the state register already holds
        // FETCH during reset, but FETCH itself raises IRWrite/PCWrite.
        if (Rst_n) begin
            bus.State = state;
            case (state)
                S_FETCH: begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                end
                S_DECODE: begin
                    if (dec.legal) begin
                        if (dec.is_j || dec.is_jal) begin
                            bus.PCWrite   = 1'b1;
                            bus.PCSrc     = 2'b10;
                            bus.InstrDone = 1'b1;
                        end
                        if (dec.is_jal) begin
                            bus.RegWrite = 1'b1;
                            bus.Jal      = 1'b1;
                        end
                        if (dec.is_jr) begin
                            bus.PCWrite   = 1'b1;
                            bus.PCSrc     = 2'b11;
                            bus.InstrDone = 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    bus.ALUControl   = dec.alu;
                    bus.ALUSrc       = dec.is_imm | dec.is_load | dec.is_store;
                    bus.ShiftControl = dec.is_shift;
                    if (dec.is_branch) begin
                        bus.PCWrite   = bus.BranchTaken;
                        bus.PCSrc     = 2'b01;
                        bus.InstrDone = 1'b1;
                    end
                end
                S_MEM: begin
                    // Address operands stay selected for the whole access.
                    bus.ALUControl = ALU_ADD;
                    bus.ALUSrc     = 1'b1;
                    if (dec.is_load)
                        bus.MemRead = dec.width;
                    else
                        bus.MemWrite = dec.width;
                    bus.InstrDone = bus.MemReady & dec.is_store;
                end
                S_WB: begin
                    bus.RegWrite  = 1'b1;
                    bus.RegDst    = dec.is_rtype | dec.is_mul;
                    bus.MemToReg  = ~dec.is_load;
                    bus.InstrDone = 1'b1;
                end
                S_TRAP: bus.Trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
//   Directed bench for multicycle_controller. A table of per-cycle records
//   {Instruction, BranchTaken, MemReady, expected outputs} is applied one row
//   per clock; trap entry and asynchronous resets are hand-written sequences.
//   Inputs change on the falling edge, outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int MUL_CYCLES = 4;

    localparam logic [31:0] I_ADD    = 32'h00221820;
    localparam logic [31:0] I_LW     = 32'h8C250008;
    localparam logic [31:0] I_LH     = 32'h84250008;
    localparam logic [31:0] I_SW     = 32'hAC250008;
    localparam logic [31:0] I_SB     = 32'hA0250008;
    localparam logic [31:0] I_BEQ    = 32'h10220003;
    localparam logic [31:0] I_BGEZ   = 32'h04210002;
    localparam logic [31:0] I_MUL    = 32'h70221802;
    localparam logic [31:0] I_JAL    = 32'h0C000010;
    localparam logic [31:0] I_J      = 32'h08000010;
    localparam logic [31:0] I_JR     = 32'h03E00008;
    localparam logic [31:0] I_SLL    = 32'h00021080;
    localparam logic [31:0] I_ORI    = 32'h34220005;
    localparam logic [31:0] I_BAD_OP = 32'hFC000000;
    localparam logic [31:0] I_BAD_FN = 32'h00221821;
    localparam logic [31:0] I_BAD_RI = 32'h04220002;

    typedef struct packed {
        logic [2:0] state;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic [1:0] mem_read;
        logic [1:0] mem_write;
        logic       jal;
        logic       shift_control;
        logic [4:0] alu_control;
        logic       instr_done;
        logic       trap;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        logic        bt;
        logic        mr;
        out_t        exp;
    } vec_t;

    logic Clk = 1'b0;
    logic Rst_n;
    int   total = 0;
    int   bad   = 0;

    vec_t  vecs[$];
    string names[$];

    always #5 Clk = ~Clk;

    multicycle_controller_if bus ();

    multicycle_controller #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    // Column order: state irw pcw pcsrc rw rdst asrc m2r mrd mwr jal sh aluc done trap
    function automatic out_t mk(input int st, input int irw, input int pcw, input int pcs,
                                input int rw, input int rdst, input int asrc, input int m2r,
                                input int mrd, input int mwr, input int jl, input int sh,
                                input int aluc, input int done, input int trp);
        out_t o;
        o.state         = 3'(st);
        o.ir_write      = 1'(irw);
        o.pc_write      = 1'(pcw);
        o.pc_src        = 2'(pcs);
        o.reg_write     = 1'(rw);
        o.reg_dst       = 1'(rdst);
        o.alu_src       = 1'(asrc);
        o.mem_to_reg    = 1'(m2r);
        o.mem_read      = 2'(mrd);
        o.mem_write     = 2'(mwr);
        o.jal           = 1'(jl);
        o.shift_control = 1'(sh);
        o.alu_control   = 5'(aluc);
        o.instr_done    = 1'(done);
        o.trap          = 1'(trp);
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.state         = bus.State;
        o.ir_write      = bus.IRWrite;
        o.pc_write      = bus.PCWrite;
        o.pc_src        = bus.PCSrc;
        o.reg_write     = bus.RegWrite;
        o.reg_dst       = bus.RegDst;
        o.alu_src       = bus.ALUSrc;
        o.mem_to_reg    = bus.MemToReg;
        o.mem_read      = bus.MemRead;
        o.mem_write     = bus.MemWrite;
        o.jal           = bus.Jal;
        o.shift_control = bus.ShiftControl;
        o.alu_control   = bus.ALUControl;
        o.instr_done    = bus.InstrDone;
        o.trap          = bus.Trap;
        return o;
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic add(input string name, input logic [31:0] ins, input int bt, input int mr,
                       input out_t e);
        vec_t v;
        v.instr = ins;
        v.bt    = 1'(bt);
        v.mr    = 1'(mr);
        v.exp   = e;
        vecs.push_back(v);
        names.push_back(name);
    endtask

    // One clock per row: drive on the falling edge, compare just after.
    task automatic apply(input string name, input vec_t v);
        @(negedge Clk);
        bus.Instruction = v.instr;
        bus.BranchTaken = v.bt;
        bus.MemReady    = v.mr;
        #1;
        check(name, sample(), v.exp);
    endtask

    task automatic run_row(input string name, input logic [31:0] ins, input int bt,
                           input int mr, input out_t e);
        vec_t v;
        v.instr = ins;
        v.bt    = 1'(bt);
        v.mr    = 1'(mr);
        v.exp   = e;
        apply(name, v);
    endtask

    // Asynchronous reset pulse starting between clock edges; outputs must be
    // all-zero immediately and across the following rising edge. Released
    // just after that edge so the next row sees FETCH.
    task automatic pulse_reset(input string name, input out_t zero);
        #2 Rst_n = 1'b0;
        #1 check({name, " async"}, sample(), zero);
        @(posedge Clk);
        #1 check({name, " held"}, sample(), zero);
        Rst_n = 1'b1;
    endtask

    initial begin
        out_t zero, o_fetch, o_dec, o_wb_r, o_ea;

        zero    = mk(0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0);
        o_fetch = mk(0, 1,1,0, 0,0,0,0, 0,0,0,0, 0,0,0);
        o_dec   = mk(1, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0);
        o_wb_r  = mk(4, 0,0,0, 1,1,0,1, 0,0,0,0, 0,1,0);
        o_ea    = mk(2, 0,0,0, 0,0,1,0, 0,0,0,0, 5'b00001,0,0);

        // add: 4 cycles, RegDst/RegWrite only in WB
        add("add F", I_ADD, 0,0, o_fetch);
        add("add D", I_ADD, 0,0, o_dec);
        add("add E", I_ADD, 0,0, mk(2, 0,0,0, 0,0,0,0, 0,0,0,0, 5'b00001,0,0));
        add("add W", I_ADD, 0,0, o_wb_r);
        // lw with two wait cycles: MEM lasts 3 cycles, done in cycle 7
        add("lw F",  I_LW, 0,0, o_fetch);
        add("lw D",  I_LW, 0,0, o_dec);
        add("lw E",  I_LW, 0,0, o_ea);
        add("lw M0", I_LW, 0,0, mk(3, 0,0,0, 0,0,1,0, 1,0,0,0, 5'b00001,0,0));
        add("lw M1", I_LW, 0,0, mk(3, 0,0,0, 0,0,1,0, 1,0,0,0, 5'b00001,0,0));
        add("lw M2", I_LW, 0,1, mk(3, 0,0,0, 0,0,1,0, 1,0,0,0, 5'b00001,0,0));
        add("lw W",  I_LW, 0,0, mk(4, 0,0,0, 1,0,0,0, 0,0,0,0, 0,1,0));
        // beq taken then not taken
        add("beqT F", I_BEQ, 1,0, o_fetch);
        add("beqT D", I_BEQ, 1,0, o_dec);
        add("beqT E", I_BEQ, 1,0, mk(2, 0,1,1, 0,0,0,0, 0,0,0,0, 5'b01100,1,0));
        add("beqN F", I_BEQ, 0,0, o_fetch);
        add("beqN D", I_BEQ, 0,0, o_dec);
        add("beqN E", I_BEQ, 0,0, mk(2, 0,0,1, 0,0,0,0, 0,0,0,0, 5'b01100,1,0));
        // mul: EXEC held MUL_CYCLES=4, done in cycle 7
        add("mul F",  I_MUL, 0,0, o_fetch);
        add("mul D",  I_MUL, 0,0, o_dec);
        add("mul E0", I_MUL, 0,0, mk(2, 0,0,0, 0,0,0,0, 0,0,0,0, 5'b00011,0,0));
        add("mul E1", I_MUL, 0,0, mk(2, 0,0,0, 0,0,0,0, 0,0,0,0, 5'b00011,0,0));
        add("mul E2", I_MUL, 0,0, mk(2, 0,0,0, 0,0,0,0, 0,0,0,0, 5'b00011,0,0));
        add("mul E3", I_MUL, 0,0, mk(2, 0,0,0, 0,0,0,0, 0,0,0,0, 5'b00011,0,0));
        add("mul W",  I_MUL, 0,0, o_wb_r);
        // jumps retire in DECODE
        add("jal F", I_JAL, 0,0, o_fetch);
        add("jal D", I_JAL, 0,0, mk(1, 0,1,2, 1,0,0,0, 0,0,1,0, 0,1,0));
        add("j F",   I_J,   0,0, o_fetch);
        add("j D",   I_J,   0,0, mk(1, 0,1,2, 0,0,0,0, 0,0,0,0, 0,1,0));
        add("jr F",  I_JR,  0,0, o_fetch);
        add("jr D",  I_JR,  0,0, mk(1, 0,1,3, 0,0,0,0, 0,0,0,0, 0,1,0));
        // sw with no wait: 4 cycles, done in MEM
        add("sw F", I_SW, 0,1, o_fetch);
        add("sw D", I_SW, 0,1, o_dec);
        add("sw E", I_SW, 0,1, o_ea);
        add("sw M", I_SW, 0,1, mk(3, 0,0,0, 0,0,1,0, 0,1,0,0, 5'b00001,1,0));
        // lh with one wait cycle
        add("lh F",  I_LH, 0,0, o_fetch);
        add("lh D",  I_LH, 0,0, o_dec);
        add("lh E",  I_LH, 0,0, o_ea);
        add("lh M0", I_LH, 0,0, mk(3, 0,0,0, 0,0,1,0, 2,0,0,0, 5'b00001,0,0));
        add("lh M1", I_LH, 0,1, mk(3, 0,0,0, 0,0,1,0, 2,0,0,0, 5'b00001,0,0));
        add("lh W",  I_LH, 0,0, mk(4, 0,0,0, 1,0,0,0, 0,0,0,0, 0,1,0));
        // sll uses shamt, ori uses the immediate and writes rt
        add("sll F", I_SLL, 0,0, o_fetch);
        add("sll D", I_SLL, 0,0, o_dec);
        add("sll E", I_SLL, 0,0, mk(2, 0,0,0, 0,0,0,0, 0,0,0,1, 5'b00100,0,0));
        add("sll W", I_SLL, 0,0, o_wb_r);
        add("ori F", I_ORI, 0,0, o_fetch);
        add("ori D", I_ORI, 0,0, o_dec);
        add("ori E", I_ORI, 0,0, mk(2, 0,0,0, 0,0,1,0, 0,0,0,0, 5'b00111,0,0));
        add("ori W", I_ORI, 0,0, mk(4, 0,0,0, 1,0,0,1, 0,0,0,0, 0,1,0));
        // REGIMM bgez shares the bne code
        add("bgez F", I_BGEZ, 1,0, o_fetch);
        add("bgez D", I_BGEZ, 1,0, o_dec);
        add("bgez E", I_BGEZ, 1,0, mk(2, 0,1,1, 0,0,0,0, 0,0,0,0, 5'b01111,1,0));

        bus.Instruction = I_ADD;
        bus.BranchTaken = 1'b0;
        bus.MemReady    = 1'b0;
        Rst_n           = 1'b0;

        // Reset state: everything 0, including IRWrite/PCWrite.
        #1 check("reset", sample(), zero);
        @(posedge Clk);
        #1 check("reset held", sample(), zero);
        Rst_n = 1'b1;

        foreach (vecs[i]) apply(names[i], vecs[i]);

        // Illegal opcode: DECODE is quiet, then TRAP is sticky.
        run_row("badop F", I_BAD_OP, 0,0, o_fetch);
        run_row("badop D", I_BAD_OP, 0,0, o_dec);
        run_row("trap 0",  I_BAD_OP, 0,1, mk(7, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1));
        run_row("trap 1",  I_ADD,    1,0, mk(7, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1));
        run_row("trap 2",  I_SW,     0,1, mk(7, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1));
        pulse_reset("trap rst", zero);

        // sb interrupted by reset in EXEC: restarts cleanly, no MemWrite.
        run_row("sb F", I_SB, 0,1, o_fetch);
        run_row("sb D", I_SB, 0,1, o_dec);
        run_row("sb E", I_SB, 0,1, o_ea);
        pulse_reset("sb rst", zero);
        run_row("post F", I_ADD, 0,1, o_fetch);
        run_row("post D", I_ADD, 0,1, o_dec);
        run_row("post E", I_ADD, 0,1, mk(2, 0,0,0, 0,0,0,0, 0,0,0,0, 5'b00001,0,0));
        run_row("post W", I_ADD, 0,1, o_wb_r);

        // Unlisted R-type funct and unlisted REGIMM rt both trap.
        run_row("badfn F", I_BAD_FN, 0,0, o_fetch);
        run_row("badfn D", I_BAD_FN, 0,0, o_dec);
        run_row("badfn T", I_BAD_FN, 0,0, mk(7, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1));
        pulse_reset("badfn rst", zero);
        run_row("badri F", I_BAD_RI, 0,0, o_fetch);
        run_row("badri D", I_BAD_RI, 0,0, o_dec);
        run_row("badri T", I_BAD_RI, 0,0, mk(7, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
